// File: rtl/kpad_emulator_if.sv
// Host key-queue handshake plus scanner row/col contacts for the keypad emulator.
// master = host/scanner side, slave = emulator side.
interface kpad_emulator_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] row;
   logic [3:0] col;
   logic       busy;
   logic       done;

   modport master (
      output key_valid, key_code, row,
      input  key_ready, col, busy, done
   );

   modport slave (
      input  key_valid, key_code, row,
      output key_ready, col, busy, done
   );
endinterface

// File: rtl/kpad_emulator.sv
// Single-key keypad model: press with LFSR chatter, hold, release with chatter,
// then an idle gap, while answering the scanner's row drive on the columns.
//
//   state        | meaning
//   S_IDLE       | waiting for a key code, key_ready high
//   S_BOUNCE_IN  | press chatter, contact follows lfsr[0]
//   S_HOLD       | solid contact
//   S_BOUNCE_OUT | release chatter, contact follows lfsr[0]
//   S_GAP        | contact open; done on the last cycle
module kpad_emulator #(
   parameter int BOUNCE_CYCLES = 8,
   parameter int HOLD_CYCLES   = 1000,
   parameter int GAP_CYCLES    = 200
) (
   input  logic           clk,
   input  logic           reset,
   kpad_emulator_if.slave kp
);
   localparam int MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAX_CYC = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   // Counters load N-1 on entry and leave the state at terminal count zero.
   localparam logic [CW-1:0] LD_BOUNCE = (BOUNCE_CYCLES > 0) ? CW'(BOUNCE_CYCLES - 1) : '0;
   localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] LD_GAP    = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOUNCE_IN,
      S_HOLD,
      S_BOUNCE_OUT,
      S_GAP
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [7:0]    lfsr;
   logic [3:0]    code;
   logic [3:0]    col_q;
   logic          contact;
   logic          accept;
   logic          cnt_tc;

   assign cnt_tc       = (cnt == '0);
   assign kp.key_ready = (state == S_IDLE) && !reset;
   assign accept       = kp.key_valid && kp.key_ready;
   assign kp.busy      = (state != S_IDLE);
   assign kp.done      = (state == S_GAP) && cnt_tc;
   assign kp.col       = col_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      contact   = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (BOUNCE_CYCLES > 0) begin
                  state_nxt = S_BOUNCE_IN;
                  cnt_nxt   = LD_BOUNCE;
               end else begin
                  state_nxt = S_HOLD;
                  cnt_nxt   = LD_HOLD;
               end
            end
         end
         S_BOUNCE_IN: begin
            contact = lfsr[0];
            if (cnt_tc) begin
               state_nxt = S_HOLD;
               cnt_nxt   = LD_HOLD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_HOLD: begin
            contact = 1'b1;
            if (cnt_tc) begin
               if (BOUNCE_CYCLES > 0) begin
                  state_nxt = S_BOUNCE_OUT;
                  cnt_nxt   = LD_BOUNCE;
               end else begin
                  state_nxt = S_GAP;
                  cnt_nxt   = LD_GAP;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_BOUNCE_OUT: begin
            contact = lfsr[0];
            if (cnt_tc) begin
               state_nxt = S_GAP;
               cnt_nxt   = LD_GAP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_tc) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // LFSR free-runs in every state so chatter is reproducible from reset alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         lfsr  <= 8'hA5;
         code  <= 4'h0;
         col_q <= 4'b0000;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (accept) begin
            code <= kp.key_code;
         end
         col_q <= (contact && kp.row[code[3:2]]) ? (4'b0001 << code[1:0]) : 4'b0000;
      end
   end
endmodule

// File: tb/tb_kpad_emulator.sv
// Bench for kpad_emulator: a clean-edge instance and a chattering instance,
// expected column values queued per cycle and popped one cycle later.
module tb_kpad_emulator;
   localparam int HOLD = 10;
   localparam int GAP  = 4;
   localparam int BNC  = 8;
   localparam int TOT0 = HOLD + GAP;
   localparam int TOT8 = 2 * BNC + HOLD + GAP;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] exp_q [$];
   logic [3:0] exp_col;
   logic [7:0] lfsr_m;

   kpad_emulator_if ia ();
   kpad_emulator_if ib ();

   kpad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut0 (
      .clk(clk), .reset(reset), .kp(ia.slave)
   );
   kpad_emulator #(.BOUNCE_CYCLES(BNC), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut8 (
      .clk(clk), .reset(reset), .kp(ib.slave)
   );

   always #5 clk = ~clk;

   // Reference LFSR: taps x^8+x^6+x^5+x^4+1 are register bits 7,5,4,3.
   always @(posedge clk) begin
      if (reset) lfsr_m <= 8'hA5;
      else       lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
   end

   // Phase m cycles after the accepting edge: 0 idle, 1 bounce in, 2 hold, 3 bounce out, 4 gap.
   function automatic int phase(int m, int b);
      if (m < 0)             return 0;
      if (m < b)             return 1;
      if (m < b + HOLD)      return 2;
      if (m < 2 * b + HOLD)  return 3;
      if (m < 2 * b + HOLD + GAP) return 4;
      return 0;
   endfunction

   function automatic logic [3:0] col_model(int ph, logic chatter, logic [3:0] code, logic [3:0] row);
      logic       touch;
      logic [3:0] oh;
      oh = 4'b0000;
      oh[code[1:0]] = 1'b1;
      touch = (ph == 2) || (((ph == 1) || (ph == 3)) && chatter);
      return (touch && row[code[3:2]]) ? oh : 4'b0000;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      ia.row = 4'b1111;
      ib.row = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({ia.col, ia.busy, ia.done, ia.key_ready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_dut0 cyc%0d: col/busy/done/ready=%b want 0000000", i,
                     {ia.col, ia.busy, ia.done, ia.key_ready});
         end
         n_vec++;
         if ({ib.col, ib.busy, ib.done, ib.key_ready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_dut8 cyc%0d: col/busy/done/ready=%b want 0000000", i,
                     {ib.col, ib.busy, ib.done, ib.key_ready});
         end
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ia.key_ready, ia.busy, ia.col} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_release_dut0: ready/busy/col=%b want 100000", {ia.key_ready, ia.busy, ia.col});
      end
      n_vec++;
      if ({ib.key_ready, ib.busy, ib.col} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_release_dut8: ready/busy/col=%b want 100000", {ib.key_ready, ib.busy, ib.col});
      end
   endtask

   // Clean-edge key against constant hit row, constant miss row, and a rotating scan.
   task automatic test_row_gating();
      logic [3:0] codes [3];
      logic [3:0] rows  [3];
      logic       rot   [3];
      logic [3:0] row_now;
      int         ph;
      codes[0] = 4'h6; rows[0] = 4'b0010; rot[0] = 1'b0;
      codes[1] = 4'h6; rows[1] = 4'b0001; rot[1] = 1'b0;
      codes[2] = 4'hF; rows[2] = 4'b0001; rot[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ia.key_valid = 1'b1;
         ia.key_code  = codes[k];
         ia.row       = rows[k];
         exp_q.push_back(col_model(0, lfsr_m[0], codes[k], rows[k]));
         @(negedge clk);
         for (int m = 0; m <= TOT0; m++) begin
            ph = phase(m, 0);
            exp_col = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
            n_vec++;
            if (ia.col !== exp_col) begin
               n_err++;
               $display("FAIL gating_col case%0d m=%0d: got %b want %b", k, m, ia.col, exp_col);
            end
            n_vec++;
            if (ia.busy !== (ph != 0)) begin
               n_err++;
               $display("FAIL gating_busy case%0d m=%0d: got %b want %b", k, m, ia.busy, (ph != 0));
            end
            n_vec++;
            if (ia.done !== (m == TOT0 - 1)) begin
               n_err++;
               $display("FAIL gating_done case%0d m=%0d: got %b want %b", k, m, ia.done, (m == TOT0 - 1));
            end
            n_vec++;
            if (ia.key_ready !== (ph == 0)) begin
               n_err++;
               $display("FAIL gating_ready case%0d m=%0d: got %b want %b", k, m, ia.key_ready, (ph == 0));
            end
            if (m == 0) ia.key_valid = 1'b0;
            row_now = rot[k] ? (4'b0001 << ((m + 1) % 4)) : rows[k];
            ia.row  = row_now;
            if (m < TOT0) begin
               exp_q.push_back(col_model(ph, lfsr_m[0], codes[k], row_now));
               @(negedge clk);
            end
         end
      end
   endtask

   // 0x6 accepted, 0x3 offered throughout; 0x3 must start right after the first idle cycle.
   task automatic test_back_to_back();
      logic [3:0] code_exp;
      int         m;
      int         ph;
      ia.key_valid = 1'b1;
      ia.key_code  = 4'h6;
      ia.row       = 4'b0011;
      exp_q.push_back(4'b0000);
      @(negedge clk);
      for (int g = 0; g <= 2 * TOT0 + 1; g++) begin
         m        = (g <= TOT0) ? g : g - TOT0 - 1;
         code_exp = (g <= TOT0) ? 4'h6 : 4'h3;
         ph       = phase(m, 0);
         exp_col  = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
         n_vec++;
         if (ia.col !== exp_col) begin
            n_err++;
            $display("FAIL b2b_col g=%0d: got %b want %b", g, ia.col, exp_col);
         end
         n_vec++;
         if (ia.busy !== (ph != 0)) begin
            n_err++;
            $display("FAIL b2b_busy g=%0d: got %b want %b", g, ia.busy, (ph != 0));
         end
         n_vec++;
         if (ia.done !== (m == TOT0 - 1)) begin
            n_err++;
            $display("FAIL b2b_done g=%0d: got %b want %b", g, ia.done, (m == TOT0 - 1));
         end
         n_vec++;
         if (ia.key_ready !== (ph == 0)) begin
            n_err++;
            $display("FAIL b2b_ready g=%0d: got %b want %b", g, ia.key_ready, (ph == 0));
         end
         if (g == 0)        ia.key_code  = 4'h3;
         if (g == TOT0 + 1) ia.key_valid = 1'b0;
         if (g < 2 * TOT0 + 1) begin
            exp_q.push_back(col_model(ph, lfsr_m[0], code_exp, ia.row));
            @(negedge clk);
         end
      end
   endtask

   // Chattering instance, full sequence with random row drive.
   task automatic test_bounce();
      logic [3:0] row_now;
      int         ph;
      ib.key_valid = 1'b1;
      ib.key_code  = 4'h9;
      ib.row       = 4'b0100;
      exp_q.push_back(4'b0000);
      @(negedge clk);
      for (int m = 0; m <= TOT8; m++) begin
         ph      = phase(m, BNC);
         exp_col = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
         n_vec++;
         if (ib.col !== exp_col) begin
            n_err++;
            $display("FAIL bounce_col m=%0d: got %b want %b", m, ib.col, exp_col);
         end
         n_vec++;
         if ({ib.busy, ib.done, ib.key_ready} !== {(ph != 0), (m == TOT8 - 1), (ph == 0)}) begin
            n_err++;
            $display("FAIL bounce_flags m=%0d: busy/done/ready=%b want %b", m,
                     {ib.busy, ib.done, ib.key_ready}, {(ph != 0), (m == TOT8 - 1), (ph == 0)});
         end
         if (m == 0) ib.key_valid = 1'b0;
         row_now = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) row_now = row_now | 4'b0100;
         ib.row = row_now;
         if (m < TOT8) begin
            exp_q.push_back(col_model(ph, lfsr_m[0], 4'h9, row_now));
            @(negedge clk);
         end
      end
   endtask

   // Chattering instance, reset asserted part way through HOLD.
   task automatic test_reset_mid();
      int ph;
      ib.key_valid = 1'b1;
      ib.key_code  = 4'h9;
      ib.row       = 4'b0100;
      exp_q.push_back(4'b0000);
      @(negedge clk);
      for (int m = 0; m <= 12; m++) begin
         ph      = phase(m, BNC);
         exp_col = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
         n_vec++;
         if (ib.col !== exp_col) begin
            n_err++;
            $display("FAIL rstmid_col m=%0d: got %b want %b", m, ib.col, exp_col);
         end
         n_vec++;
         if (ib.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy m=%0d: got %b want 1", m, ib.busy);
         end
         if (m == 0) ib.key_valid = 1'b0;
         if (m < 12) begin
            exp_q.push_back(col_model(ph, lfsr_m[0], 4'h9, ib.row));
            @(negedge clk);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({ib.col, ib.busy, ib.done, ib.key_ready} !== 7'b0) begin
         n_err++;
         $display("FAIL rstmid_abort: col/busy/done/ready=%b want 0000000", {ib.col, ib.busy, ib.done, ib.key_ready});
      end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({ib.key_ready, ib.busy, ib.col} !== 6'b100000) begin
         n_err++;
         $display("FAIL rstmid_idle: ready/busy/col=%b want 100000", {ib.key_ready, ib.busy, ib.col});
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end
   endtask

   initial begin
      ia.key_valid = 1'b0;
      ia.key_code  = 4'h0;
      ia.row       = 4'b0000;
      ib.key_valid = 1'b0;
      ib.key_code  = 4'h0;
      ib.row       = 4'b0000;
      test_reset();
      test_row_gating();
      test_back_to_back();
      test_bounce();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
